// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch front end's redirect input, instruction
// memory request/response channel and decode-side output slot.
//   master : fetch unit side (drives the request and the decode slot)
//   slave  : environment side (execution stage, instruction memory, decode)
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    modport master (
        input  redirect_valid, redirect_target,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_ready,
        output imem_req_valid, imem_req_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_target,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_ready,
        input  imem_req_valid, imem_req_addr,
        input  out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the fetch PC, issues word
// fetches with at most one request outstanding, buffers one instruction for
// decode and squashes wrong-path responses after a taken-branch redirect.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master: redirect in, imem req/rsp, decode slot out
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [31:0] out_instr_q;
    logic        req_valid;
    logic        req_fire;
    logic        load_slot;

    // Target low bits are dropped; fetches are always word aligned.
    logic unused_tgt_lo;
    assign unused_tgt_lo = ^bus.redirect_target[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic. A redirect while waiting turns the in-flight fetch
    // into a squash; a response in WAIT always returns to IDLE whether it is
    // kept or dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = WAIT;
            WAIT: begin
                if (bus.imem_rsp_valid)      state_nxt = IDLE;
                else if (bus.redirect_valid) state_nxt = SQUASH;
            end
            SQUASH:  if (bus.imem_rsp_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control logic. Issue only when the slot will be free by the
    // time the response lands, so a response never finds the slot occupied.
    always_comb begin
        req_valid = (state == IDLE) && !bus.redirect_valid
                    && (!out_valid_q || bus.out_ready);
        req_fire  = req_valid && bus.imem_req_ready;
        load_slot = (state == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_instr      = out_instr_q;

    // PC and outstanding-request address
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= 32'h0;
        end else if (bus.redirect_valid) begin
            pc <= {bus.redirect_target[31:2], 2'b00};
        end else if (req_fire) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
        end
    end

    // Decode slot: redirect kills it outright; otherwise a load wins over
    // a consume in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'h0;
            out_instr_q <= 32'h0;
        end else if (bus.redirect_valid) begin
            out_valid_q <= 1'b0;
        end else if (load_slot) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= req_pc;
            out_instr_q <= bus.imem_rsp_data;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
